// File: rtl/csr_led_pwm.sv
// CSR-mapped 8-channel LED PWM: two 32-bit duty words, prescaled 255-step PWM.
// Define CSR_LED_PWM_SYNC_EN to double-buffer duties so updates land on period boundaries.
`timescale 1ns/1ps

module csr_led_pwm #(
  parameter logic [11:0] BASE_ADDR = 12'h7c2,
  parameter int          PRESCALE  = 47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [1:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic [7:0]  leds
);

  localparam int             PW       = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0]  P_MAX    = PW'(PRESCALE);
  localparam logic [7:0]     C_LAST   = 8'd254;
  localparam logic [63:0]    S_RESET  = 64'hFF00_0000_0000_00FF;
  localparam logic [11:0]    ADDR_B   = BASE_ADDR + 12'd1;

  localparam logic [1:0] MOD_NONE  = 2'b00;
  localparam logic [1:0] MOD_WRITE = 2'b01;
  localparam logic [1:0] MOD_SET   = 2'b10;
  localparam logic [1:0] MOD_CLEAR = 2'b11;

  // Access is decoded purely from addr; the strobe is accepted but not needed.
  logic unused_read;
  assign unused_read = read;

  logic [7:0][7:0] s_q, s_d;
  logic [PW-1:0]   p_q, p_d;
  logic [7:0]      c_q, c_d;
  logic [7:0]      leds_q, leds_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic [7:0][7:0] duty;

  logic        hit_a, hit_b, tick, wrap;
  logic [31:0] word_cur, word_new;

  // CSR decode and read-modify-write of the addressed duty word.
  always_comb begin
    hit_a    = (addr == BASE_ADDR);
    hit_b    = (addr == ADDR_B);
    word_cur = hit_b ? s_q[7:4] : s_q[3:0];
    unique case (modify)
      MOD_WRITE: word_new = wdata;
      MOD_SET:   word_new = word_cur | wdata;
      MOD_CLEAR: word_new = word_cur & ~wdata;
      default:   word_new = word_cur;
    endcase
    s_d = s_q;
    if (hit_a) s_d[3:0] = word_new;
    if (hit_b) s_d[7:4] = word_new;
    valid_d = hit_a | hit_b;
    rdata_d = valid_d ? word_cur : 32'h0;
  end

  // Prescaler and 255-step PWM counter (0..254).
  always_comb begin
    tick = (p_q == P_MAX);
    p_d  = tick ? '0 : p_q + 1'b1;
    wrap = tick && (c_q == C_LAST);
    c_d  = c_q;
    if (tick) c_d = wrap ? 8'd0 : c_q + 8'd1;
  end

`ifdef CSR_LED_PWM_SYNC_EN
  logic [7:0][7:0] a_q, a_d;

  // The copy reads the registered S, so a write on the boundary edge waits a period.
  always_comb begin
    a_d = wrap ? s_q : a_q;
  end

  always_ff @(posedge clk) begin
    if (rst) a_q <= S_RESET;
    else     a_q <= a_d;
  end

  assign duty = a_q;
`else
  assign duty = s_q;
`endif

  always_comb begin
    leds_d = '0;
    for (int i = 0; i < 8; i++) begin
      leds_d[i] = (c_q < duty[i]);
    end
  end

  // NOTE: the duty bank is a handful of flops with defined power-up LED state, so it is
  // reset like any other register rather than treated as an unreset memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= S_RESET;
      p_q     <= '0;
      c_q     <= 8'd0;
      leds_q  <= 8'h00;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      p_q     <= p_d;
      c_q     <= c_d;
      leds_q  <= leds_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_csr_led_pwm.sv
// Directed bench for csr_led_pwm at PRESCALE=0 with a CSR response scoreboard.
// Expectations follow CSR_LED_PWM_SYNC_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_csr_led_pwm;

  logic        clk;
  logic        rst;
  logic        read;
  logic [1:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic [7:0]  leds;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  // Reference PWM counter: value of C after each edge.
  int m_c = 0;

`ifdef CSR_LED_PWM_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  csr_led_pwm #(.BASE_ADDR(12'h7c2), .PRESCALE(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .leds   (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_c <= 0;
    else     m_c <= (m_c == 254) ? 0 : m_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input string tag, input logic [11:0] a, input logic [1:0] m,
                     input logic [31:0] wd, input logic ev, input logic [31:0] er);
    exp_t e;
    addr   = a;
    modify = m;
    wdata  = wd;
    read   = (m == 2'b00);
    exp_q.push_back('{tag, ev, er});
    step();
    addr   = 12'h000;
    modify = 2'b00;
    wdata  = 32'h0;
    read   = 1'b0;
    e = exp_q.pop_front();
    check({e.tag, ".valid"}, {31'b0, valid}, {31'b0, e.valid});
    check({e.tag, ".rdata"}, rdata, e.rdata);
  endtask

  task automatic wait_c(input int target);
    int n = 0;
    while (m_c != target && n < 600) begin
      step();
      n++;
    end
  endtask

  task automatic count_period(output int n0, output int n4, output int n7);
    n0 = 0; n4 = 0; n7 = 0;
    repeat (255) begin
      step();
      n0 += int'(leds[0]);
      n4 += int'(leds[4]);
      n7 += int'(leds[7]);
    end
  endtask

  initial begin
    int n0, n4, n7, bad;

    rst = 1'b1; read = 1'b0; modify = 2'b00; wdata = 32'h0; addr = 12'h000;
    repeat (3) step();
    check("rst.leds",  {24'b0, leds}, 32'h00);
    check("rst.valid", {31'b0, valid}, 32'h0);
    check("rst.rdata", rdata, 32'h0);
    csr("rst_write_ignored", 12'h7c2, 2'b01, 32'h1234_5678, 1'b0, 32'h0);

    // Release: both always-on channels for a whole period.
    rst = 1'b0;
    bad = 0;
    repeat (255) begin
      step();
      if (leds !== 8'h81) bad++;
    end
    check("reset_pattern_bad_cycles", bad, 0);

    // Plain write to word A; duty 128 from the next period on.
    csr("write_a", 12'h7c2, 2'b01, 32'h0000_0080, 1'b1, 32'h0000_00FF);
    wait_c(0);
    count_period(n0, n4, n7);
    check("duty128.led0", n0, 128);
    check("duty128.led7", n7, 255);

    // Set then clear on word B, then read back.
    csr("set_b",   12'h7c3, 2'b10, 32'h0000_0040, 1'b1, 32'hFF00_0000);
    csr("clear_b", 12'h7c3, 2'b11, 32'hFF00_0000, 1'b1, 32'hFF00_0040);
    csr("read_b",  12'h7c3, 2'b00, 32'h0,         1'b1, 32'h0000_0040);

    // Write on the wrap edge: synced build keeps the old duty one more period.
    wait_c(254);
    csr("race_write", 12'h7c2, 2'b01, 32'h0000_0010, 1'b1, 32'h0000_0080);
    count_period(n0, n4, n7);
    check("race_p1.led0", n0, SYNC ? 128 : 16);
    count_period(n0, n4, n7);
    check("race_p2.led0", n0, 16);
    check("race_p2.led4", n4, 64);
    check("race_p2.led7", n7, 0);

    // Decode: neighbouring address is ignored.
    csr("miss_7c1", 12'h7c1, 2'b01, 32'hDEAD_BEEF, 1'b0, 32'h0);
    csr("read_a",   12'h7c2, 2'b00, 32'h0, 1'b1, 32'h0000_0010);
    csr("read_b2",  12'h7c3, 2'b00, 32'h0, 1'b1, 32'h0000_0040);

    // Mid-period duty 0: immediate in the direct build, deferred when synced.
    wait_c(5);
    csr("zero_a", 12'h7c2, 2'b01, 32'h0, 1'b1, 32'h0000_0010);
    check("zero.write_edge.led0", {31'b0, leds[0]}, 32'h1);
    step();
    check("zero.next_edge.led0", {31'b0, leds[0]}, SYNC ? 32'h1 : 32'h0);

    // Mid-period reset: accesses ignored, then restored reset duties.
    rst = 1'b1;
    repeat (2) step();
    csr("rst2_write_ignored", 12'h7c2, 2'b01, 32'hAAAA_AAAA, 1'b0, 32'h0);
    check("rst2.leds", {24'b0, leds}, 32'h00);
    rst = 1'b0;
    step();
    check("rst2.release.leds", {24'b0, leds}, 32'h81);
    csr("rst2.read_a", 12'h7c2, 2'b00, 32'h0, 1'b1, 32'h0000_00FF);
    csr("rst2.read_b", 12'h7c3, 2'b00, 32'h0, 1'b1, 32'hFF00_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
